// File: rtl/jtkcpu_idxseq.sv
`default_nettype none
// ============================================================================
// Module      : jtkcpu_idxseq
// Description : KCPU indexed-addressing sequencer. Resolves a postbyte into
//               an effective address: fetches 0/1/2 offset bytes, adds them
//               to the base, strobes auto-inc/dec writeback and optionally
//               follows a 16-bit indirect pointer.
//               Optional macro JTKCPU_IDXSEQ_ILLEGAL_EN adds the 'illegal'
//               output and flags modes 7, A and E.
// Revision    : 1.0 - initial release
// ============================================================================
module jtkcpu_idxseq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  postbyte,
    input  logic [15:0] idx_reg,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] pc,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_din,
    input  logic        mem_ok,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic [15:0] pc_next,
    output logic [1:0]  idx_sel,
    output logic        idx_we,
    output logic [15:0] idx_wdata
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_fetch_hi = 3'd1;
    localparam logic [2:0] c_st_fetch_lo = 3'd2;
    localparam logic [2:0] c_st_calc     = 3'd3;
    localparam logic [2:0] c_st_ind_hi   = 3'd4;
    localparam logic [2:0] c_st_ind_lo   = 3'd5;
    localparam logic [2:0] c_st_done     = 3'd6;

    logic [2:0]  r_state, w_next;

    // Postbyte decode (valid when start is sampled)
    logic [1:0]  w_fetch;
    logic        w_pcrel, w_abs, w_ind, w_wb_en, w_illegal;
    logic [15:0] w_off, w_wb_add;

    // Latched transaction context
    logic [1:0]  r_fetch;
    logic        r_pcrel, r_abs, r_ind, r_wb_en, r_ill;
    logic [15:0] r_off, r_wb_add, r_base, r_fp, r_ea;
    logic [7:0]  r_hi, r_lo;
    logic [1:0]  r_sel;

    logic [15:0] w_base, w_offset, w_sum;

    // Decode the postbyte into fetch count, base selection and offset source
    always_comb begin
        w_fetch   = 2'd0;
        w_pcrel   = 1'b0;
        w_abs     = 1'b0;
        w_ind     = 1'b0;
        w_wb_en   = 1'b0;
        w_wb_add  = 16'h0000;
        w_off     = 16'h0000;
        w_illegal = 1'b0;
        if (postbyte[7]) begin
            w_off = {{11{postbyte[4]}}, postbyte[4:0]};
        end else begin
            w_ind = postbyte[4];
            case (postbyte[3:0])
                4'h0: begin w_wb_en = 1'b1; w_wb_add = 16'h0001; end
                4'h1: begin w_wb_en = 1'b1; w_wb_add = 16'h0002; end
                // Pre-decrement: the address and the writeback share base-n
                4'h2: begin w_wb_en = 1'b1; w_wb_add = 16'hFFFF; w_off = 16'hFFFF; end
                4'h3: begin w_wb_en = 1'b1; w_wb_add = 16'hFFFE; w_off = 16'hFFFE; end
                4'h5: w_off = {{8{b[7]}}, b};
                4'h6: w_off = {{8{a[7]}}, a};
                4'h8: w_fetch = 2'd1;
                4'h9: w_fetch = 2'd2;
                4'hB: w_off = {a, b};
                4'hC: begin w_fetch = 2'd1; w_pcrel = 1'b1; end
                4'hD: begin w_fetch = 2'd2; w_pcrel = 1'b1; end
                4'hF: begin w_fetch = 2'd2; w_abs = 1'b1; w_ind = 1'b1; end
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
                4'h7, 4'hA, 4'hE: begin w_illegal = 1'b1; w_ind = 1'b0; end
`endif
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if (w_illegal)            w_next = c_st_done;
                    else if (w_fetch == 2'd2) w_next = c_st_fetch_hi;
                    else if (w_fetch == 2'd1) w_next = c_st_fetch_lo;
                    else                      w_next = c_st_calc;
                end
            end
            c_st_fetch_hi: if (mem_ok) w_next = c_st_fetch_lo;
            c_st_fetch_lo: if (mem_ok) w_next = c_st_calc;
            c_st_calc:     w_next = r_ind ? c_st_ind_hi : c_st_done;
            c_st_ind_hi:   if (mem_ok) w_next = c_st_ind_lo;
            c_st_ind_lo:   if (mem_ok) w_next = c_st_done;
            c_st_done:     w_next = c_st_idle;
            default:       w_next = c_st_idle;
        endcase
    end

    // Address arithmetic; PC-relative modes use the pointer after the fetch
    always_comb begin
        w_base   = r_abs ? 16'h0000 : (r_pcrel ? r_fp : r_base);
        w_offset = (r_fetch == 2'd2) ? {r_hi, r_lo} :
                   (r_fetch == 2'd1) ? {{8{r_lo[7]}}, r_lo} : r_off;
        w_sum    = w_base + w_offset;
    end

    // Datapath registers: context capture, byte fetches and ea updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch  <= 2'd0;
            r_pcrel  <= 1'b0;
            r_abs    <= 1'b0;
            r_ind    <= 1'b0;
            r_wb_en  <= 1'b0;
            r_ill    <= 1'b0;
            r_off    <= 16'h0000;
            r_wb_add <= 16'h0000;
            r_base   <= 16'h0000;
            r_fp     <= 16'h0000;
            r_ea     <= 16'h0000;
            r_hi     <= 8'h00;
            r_lo     <= 8'h00;
            r_sel    <= 2'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_fetch  <= w_fetch;
                        r_pcrel  <= w_pcrel;
                        r_abs    <= w_abs;
                        r_ind    <= w_ind;
                        r_wb_en  <= w_wb_en;
                        r_ill    <= w_illegal;
                        r_off    <= w_off;
                        r_wb_add <= w_wb_add;
                        r_base   <= idx_reg;
                        r_fp     <= pc;
                        r_sel    <= postbyte[6:5];
                        if (w_illegal) r_ea <= idx_reg;
                    end
                end
                c_st_fetch_hi: begin
                    if (mem_ok) begin
                        r_hi <= mem_din;
                        r_fp <= r_fp + 16'd1;
                    end
                end
                c_st_fetch_lo: begin
                    if (mem_ok) begin
                        r_lo <= mem_din;
                        r_fp <= r_fp + 16'd1;
                    end
                end
                c_st_calc:   r_ea <= w_sum;
                c_st_ind_hi: if (mem_ok) r_hi <= mem_din;
                c_st_ind_lo: if (mem_ok) r_ea <= {r_hi, mem_din};
                default: ;
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = 16'h0000;
        busy      = (r_state != c_st_idle);
        done      = (r_state == c_st_done);
        idx_we    = (r_state == c_st_calc) && r_wb_en;
        idx_wdata = idx_we ? (r_base + r_wb_add) : 16'h0000;
        case (r_state)
            c_st_fetch_hi, c_st_fetch_lo: begin
                mem_rd   = 1'b1;
                mem_addr = r_fp;
            end
            c_st_ind_hi: begin
                mem_rd   = 1'b1;
                mem_addr = r_ea;
            end
            c_st_ind_lo: begin
                mem_rd   = 1'b1;
                mem_addr = r_ea + 16'd1;
            end
            default: ;
        endcase
    end

    assign ea      = r_ea;
    assign pc_next = r_fp;
    assign idx_sel = r_sel;
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
    assign illegal = done && r_ill;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_idxseq.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtkcpu_idxseq
// Description : Scoreboard bench for jtkcpu_idxseq with a wait-state memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtkcpu_idxseq;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0]  postbyte = 8'h00, a = 8'h00, b = 8'h00, mem_din = 8'h00;
    logic [15:0] idx_reg = 16'h0000, pc = 16'h0000;
    logic        mem_ok = 1'b0;
    logic        mem_rd, busy, done, idx_we;
    logic [15:0] mem_addr, ea, pc_next, idx_wdata;
    logic [1:0]  idx_sel;
    logic        ill;
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
    logic        illegal;
    assign ill = illegal;
`else
    assign ill = 1'b0;
`endif

    jtkcpu_idxseq dut (
        .clk(clk), .rst(rst), .start(start), .postbyte(postbyte),
        .idx_reg(idx_reg), .a(a), .b(b), .pc(pc),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ok(mem_ok),
        .busy(busy), .done(done), .ea(ea), .pc_next(pc_next),
        .idx_sel(idx_sel), .idx_we(idx_we), .idx_wdata(idx_wdata)
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ea;
        logic [15:0] pcn;
        logic        we;
        logic [15:0] wd;
        logic [1:0]  sel;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    logic [7:0]  mem [0:65535];
    int          n_vec = 0, n_err = 0;
    int          waits = 0;

    // Memory model: acknowledges after 'waits' stall cycles, checks addresses
    initial begin
        int wcnt;
        logic [15:0] ex;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_rd && !rst) begin
                if (wcnt == waits) begin
                    mem_ok  = 1'b1;
                    mem_din = mem[mem_addr];
                    wcnt    = 0;
                    n_vec++;
                    if (addr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rd_addr: got read at %h, none expected", mem_addr);
                    end else begin
                        ex = addr_q.pop_front();
                        if (mem_addr !== ex) begin
                            n_err++;
                            $display("FAIL rd_addr: got %h want %h", mem_addr, ex);
                        end
                    end
                end else begin
                    mem_ok = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ok = 1'b0;
                wcnt   = 0;
            end
        end
    end

    // Monitor: tracks the writeback strobe and checks each done against the queue
    initial begin
        logic        seen_we;
        logic [15:0] seen_wd;
        exp_t        e, g;
        seen_we = 1'b0;
        seen_wd = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen_we = 1'b0;
            end else begin
                if (idx_we) begin
                    seen_we = 1'b1;
                    seen_wd = idx_wdata;
                end
                if (done) begin
                    n_vec++;
                    g = '{ea: ea, pcn: pc_next, we: seen_we,
                          wd: seen_we ? seen_wd : 16'h0000, sel: idx_sel, ill: ill};
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL result: unexpected done, ea=%h", ea);
                    end else begin
                        e = exp_q.pop_front();
                        if (g !== e || busy !== 1'b1) begin
                            n_err++;
                            $display("FAIL result: got ea=%h pcn=%h we=%b wd=%h sel=%0d ill=%b busy=%b want ea=%h pcn=%h we=%b wd=%h sel=%0d ill=%b busy=1",
                                     g.ea, g.pcn, g.we, g.wd, g.sel, g.ill, busy,
                                     e.ea, e.pcn, e.we, e.wd, e.sel, e.ill);
                        end
                    end
                    seen_we = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One transaction: issue start, scramble inputs, measure latency
    task automatic run(input logic [7:0] pb, input logic [15:0] ix,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] p, input int w, input int lat,
                       input logic [15:0] e_ea, input logic [15:0] e_pcn,
                       input logic e_we, input logic [15:0] e_wd,
                       input logic e_ill, input bit poke);
        exp_t e;
        int   n;
        bit   got;
        e = '{ea: e_ea, pcn: e_pcn, we: e_we, wd: e_wd, sel: pb[6:5], ill: e_ill};
        exp_q.push_back(e);
        waits = w;
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        postbyte = pb; idx_reg = ix; a = aa; b = bb; pc = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idx_reg = 16'hDEAD; a = 8'h5A; b = 8'hA5; pc = 16'hBEEF; postbyte = 8'h80;
        n = 1;
        got = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            start = poke && (n == 3);
            @(posedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", {63'd0, got}, 64'd1);
        check("latency_cycles", 64'(n), 64'(lat));
        if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("done_start_ignored", {63'd0, busy}, 64'd0);
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {mem_rd, busy, done, idx_we, ea, pc_next, idx_sel, idx_wdata},
              64'd0);
        rst = 1'b0;

        mem[16'h4000] = 8'h80; mem[16'h4001] = 8'h10;
        mem[16'h0100] = 8'hFF; mem[16'h0101] = 8'hFF;
        mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
        mem[16'h2000] = 8'hFE;
        mem[16'h3000] = 8'h01; mem[16'h3001] = 8'h00;
        mem[16'h7000] = 8'h05;
        mem[16'h8000] = 8'hAB; mem[16'h8001] = 8'hCD;

        //   pb     idx       a      b      pc       w lat ea       pc_next  we wdata    ill poke
        run(8'h9F, 16'h1000, 8'h00, 8'h00, 16'h5000, 0, 2, 16'h0FFF, 16'h5000, 0, 16'h0000, 0, 0);
        run(8'h01, 16'h2000, 8'h00, 8'h00, 16'h6000, 0, 2, 16'h2000, 16'h6000, 1, 16'h2002, 0, 0);
        run(8'h03, 16'h0001, 8'h00, 8'h00, 16'h6000, 0, 2, 16'hFFFF, 16'h6000, 1, 16'hFFFF, 0, 0);
        addr_q.push_back(16'h4000); addr_q.push_back(16'h4001);
        run(8'h09, 16'h9000, 8'h00, 8'h00, 16'h4000, 2, 8, 16'h1010, 16'h4002, 0, 16'h0000, 0, 1);
        addr_q.push_back(16'h0100); addr_q.push_back(16'h0101);
        addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000);
        run(8'h1F, 16'h5555, 8'h00, 8'h00, 16'h0100, 0, 6, 16'h1234, 16'h0102, 0, 16'h0000, 0, 0);
        run(8'h65, 16'h0100, 8'h00, 8'h80, 16'h1111, 0, 2, 16'h0080, 16'h1111, 0, 16'h0000, 0, 0);
        run(8'h26, 16'h1000, 8'h7F, 8'h00, 16'h1111, 0, 2, 16'h107F, 16'h1111, 0, 16'h0000, 0, 0);
        run(8'h4B, 16'hF000, 8'h12, 8'h34, 16'h1111, 0, 2, 16'h0234, 16'h1111, 0, 16'h0000, 0, 0);
        addr_q.push_back(16'h2000);
        run(8'h0C, 16'h9999, 8'h00, 8'h00, 16'h2000, 1, 4, 16'h1FFF, 16'h2001, 0, 16'h0000, 0, 0);
        addr_q.push_back(16'h3000); addr_q.push_back(16'h3001);
        run(8'h0D, 16'h9999, 8'h00, 8'h00, 16'h3000, 0, 4, 16'h3102, 16'h3002, 0, 16'h0000, 0, 0);
        addr_q.push_back(16'h7000);
        run(8'h08, 16'h00FF, 8'h00, 8'h00, 16'h7000, 0, 3, 16'h0104, 16'h7001, 0, 16'h0000, 0, 0);
        run(8'h00, 16'hFFFF, 8'h00, 8'h00, 16'h1111, 0, 2, 16'hFFFF, 16'h1111, 1, 16'h0000, 0, 0);
        run(8'h02, 16'h0000, 8'h00, 8'h00, 16'h1111, 0, 2, 16'hFFFF, 16'h1111, 1, 16'hFFFF, 0, 0);
        run(8'h90, 16'h0010, 8'h00, 8'h00, 16'h1111, 0, 2, 16'h0000, 16'h1111, 0, 16'h0000, 0, 0);
        addr_q.push_back(16'h8000); addr_q.push_back(16'h8001);
        run(8'h14, 16'h8000, 8'h00, 8'h00, 16'h1111, 0, 4, 16'hABCD, 16'h1111, 0, 16'h0000, 0, 0);
`ifdef JTKCPU_IDXSEQ_ILLEGAL_EN
        run(8'h07, 16'h4567, 8'h00, 8'h00, 16'h1111, 0, 1, 16'h4567, 16'h1111, 0, 16'h0000, 1, 0);
`else
        run(8'h07, 16'h4567, 8'h00, 8'h00, 16'h1111, 0, 2, 16'h4567, 16'h1111, 0, 16'h0000, 0, 0);
`endif

        // Reset while the second offset byte is being read
        waits = 3;
        addr_q.push_back(16'h4000); addr_q.push_back(16'h4001);
        @(negedge clk);
        postbyte = 8'h09; idx_reg = 16'h9000; pc = 16'h4000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 16'h4001) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach_fetch_lo", {63'd0, seen}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_abort", {61'd0, mem_rd, busy, done}, 64'd0);
        addr_q.delete();
        repeat (2) @(posedge clk);
        addr_q.push_back(16'h4000); addr_q.push_back(16'h4001);
        run(8'h09, 16'h9000, 8'h00, 8'h00, 16'h4000, 0, 4, 16'h1010, 16'h4002, 0, 16'h0000, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("reads_drained", 64'(addr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtkcpu_idxseq.md
Name: jtkcpu_idxseq

Overview:
- Multi-cycle sequencer that resolves a KCPU indexed-addressing postbyte into a final effective address.
- Fetches the 0/1/2 offset bytes that follow the postbyte from the instruction stream.
- Computes base+offset, performs auto-increment/decrement writeback, and optionally fetches a 16-bit indirect pointer.
- Sits between the control unit and the memory bus arbiter; the control unit starts it and waits for done.

Parameters:
- none

Ports:
- clk        in   1   system clock
- rst        in   1   synchronous active-high reset
- start      in   1   one-cycle request; sampled only in IDLE
- postbyte   in   8   indexed postbyte, sampled with start
- idx_reg    in   16  selected index register value, sampled with start
- a          in   8   accumulator A, sampled with start
- b          in   8   accumulator B, sampled with start
- pc         in   16  address of first byte after postbyte, sampled with start
- mem_rd     out  1   byte read request
- mem_addr   out  16  read address, stable while mem_rd=1
- mem_din    in   8   read data, valid when mem_ok=1
- mem_ok     in   1   read acknowledge
- busy       out  1   high from the cycle after start until done inclusive
- done       out  1   one-cycle pulse; ea and pc_next valid
- ea         out  16  effective address, held until next start
- pc_next    out  16  pc advanced past consumed offset bytes
- idx_sel    out  2   latched postbyte[6:5] (X,Y,U,S)
- idx_we     out  1   one-cycle index writeback strobe
- idx_wdata  out  16  writeback value

Behaviour:
- Reset (synchronous, any state): state=IDLE; all outputs 0; any in-flight read is abandoned.
- Postbyte encoding, postbyte[7]=1:
  - offset = sign-extended postbyte[4:0]; no fetch; no indirect; base=idx_reg.
- Postbyte encoding, postbyte[7]=0: ind=postbyte[4], mode=postbyte[3:0]. Fetch counts are bytes.
  - 0 ,R+: off 0, fetch 0; writeback base+1.
  - 1 ,R++: off 0, fetch 0; writeback base+2.
  - 2 ,-R: ea=base-1, fetch 0; writeback same.
  - 3 ,--R: ea=base-2, fetch 0; writeback same.
  - 4 ,R: off 0, fetch 0.
  - 5 B,R: off sext(b), fetch 0.
  - 6 A,R: off sext(a), fetch 0.
  - 8 n8,R: off sext(n8), fetch 1.
  - 9 n16,R: off n16, fetch 2.
  - B D,R: off {a,b}, fetch 0.
  - C n8,PC: off sext(n8), fetch 1; base=pc_next.
  - D n16,PC: off n16, fetch 2; base=pc_next.
  - F [n16]: ea=n16, fetch 2; ind forced 1.
  - 7, A, E: off 0, fetch 0.
- States: IDLE -> FETCH_HI (2-byte only) -> FETCH_LO (1/2-byte) -> CALC -> IND_HI -> IND_LO (ind only) -> DONE -> IDLE.
- Fetch pointer fp is loaded from pc at start and increments after each acknowledged offset byte; pc_next=fp.
- Multi-byte values are big-endian (high byte first).
- Read handshake:
  - mem_rd and mem_addr are held stable until a cycle with mem_ok=1; data is captured in that cycle.
  - The next request may issue the following cycle.
  - mem_ok while mem_rd=0 is ignored.
- CALC (1 cycle): ea = base+offset, modulo 2^16 (wraps silently); idx_we pulses here for modes 0-3.
- Indirect:
  - mem_addr=ea, then ea+1; the ea+1 read wraps FFFF->0000.
  - ea is replaced with {hi,lo} at the end of IND_LO.
- DONE: done=1 for one cycle; busy=1 in the same cycle.
- Latency, start at cycle 0 with zero-wait memory:
  - no fetch, no indirect: done at cycle 2.
  - Each byte read adds 1 cycle plus memory wait cycles.
- start while busy is ignored.
- start in the DONE cycle is also ignored.

Optional Feature:
- Macro: JTKCPU_IDXSEQ_ILLEGAL_EN.
- Defined:
  - Extra output illegal (1 bit).
  - For modes 7, A, E, skip CALC and go directly to DONE with illegal=1 alongside done.
  - ea=idx_reg; no writeback.
- Undefined:
  - Port absent.
  - Modes 7, A, E behave as ,R.

Test Plan:
- postbyte=0x9F (5-bit, -1), idx_reg=0x1000, start -> done at cycle 2; ea=0x0FFF; no mem_rd; pc_next=pc.
- postbyte=0x01 (,X++), idx_reg=0x2000 -> ea=0x2000; idx_we=1 in CALC with idx_wdata=0x2002.
- postbyte=0x03 (,--R), idx_reg=0x0001 -> ea=0xFFFF; idx_wdata=0xFFFF (wrap).
- postbyte=0x09, pc=0x4000, memory 0x4000=0x80, 0x4001=0x10, idx_reg=0x9000, 2 wait cycles per read -> reads at 0x4000 then 0x4001; ea=0x1010; pc_next=0x4002.
- postbyte=0x1F, pc=0x0100, mem[0x100..0x101]=0xFF,0xFF, mem[0xFFFF]=0x12, mem[0x0000]=0x34 -> indirect reads at 0xFFFF then 0x0000; ea=0x1234.
- rst asserted during FETCH_LO with mem_rd high -> next cycle mem_rd=0, busy=0, no done; a fresh start afterwards completes normally.
